hazard_scoreboard: RTL and testbench

- Parametrised replacement for the fixed hazard-detect and forwarding pair in the pipelined MIPS core.
- Tracks in-flight register writers across a configurable number of post-ID stages.
- Raises a load-use stall toward PC and IF/ID, and hands the EX-stage operand muxes registered forwarding selects.
- Sits between decode (ID) and the EX operand muxes and counts stall cycles for performance readout.

---
 rtl/hazard_scoreboard.sv | 136 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writers behind ID, raises the
// load-use stall toward PC and IF/ID, produces registered EX forwarding
// selects, and counts stall cycles for performance readout.
module hazard_scoreboard #(
  parameter int RA_W     = 5,   // register address width
  parameter int STAGES   = 3,   // tracked stages after ID (0 = EX, 1 = MEM, 2 = WB, ...)
  parameter int LOAD_RDY = 2,   // first stage index where load data can be forwarded
  parameter int CNT_W    = 16,  // stall counter width
  parameter int SEL_W    = 2    // forward select width, 2^SEL_W >= STAGES
) (
  input  logic             clk_i,
  input  logic             rst_i,          // asynchronous, active low
  input  logic             id_valid_i,
  input  logic [RA_W-1:0]  id_rs_i,
  input  logic [RA_W-1:0]  id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_load_i,
  input  logic             ex_flush_i,
  output logic             stall_o,
  output logic [SEL_W-1:0] fwd_rs_o,
  output logic [SEL_W-1:0] fwd_rt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Writer entries, index 0 is the instruction currently in EX.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] ld_q;
  logic [STAGES-1:0] ld_d;
  logic [RA_W-1:0]   rd_q [STAGES];
  logic [RA_W-1:0]   rd_d [STAGES];

  logic [SEL_W-1:0]  fwd_rs_q;
  logic [SEL_W-1:0]  fwd_rs_d;
  logic [SEL_W-1:0]  fwd_rt_q;
  logic [SEL_W-1:0]  fwd_rt_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              rs_req;
  logic              rt_req;
  logic [STAGES-1:0] rs_hit;
  logic [STAGES-1:0] rt_hit;
  logic              rs_stall;
  logic              rt_stall;
  logic [SEL_W-1:0]  rs_sel;
  logic [SEL_W-1:0]  rt_sel;
  logic              bubble;

  // A source only looks for writers when it is really read and is not $0.
  assign rs_req = id_valid_i & id_use_rs_i & (id_rs_i != '0);
  assign rt_req = id_valid_i & id_use_rt_i & (id_rt_i != '0);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_match
      assign rs_hit[gi] = rs_req & v_q[gi] & (rd_q[gi] == id_rs_i);
      assign rt_hit[gi] = rt_req & v_q[gi] & (rd_q[gi] == id_rt_i);
    end
  endgenerate

  // Youngest-match priority: walk from oldest to youngest so the lowest
  // index overwrites. The oldest stage maps to select 0 because the
  // write-first register file already returns its result.
  always_comb begin
    rs_stall = 1'b0;
    rt_stall = 1'b0;
    rs_sel   = '0;
    rt_sel   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (rs_hit[k]) begin
        rs_stall = ld_q[k] && (k < LOAD_RDY - 1);
        rs_sel   = (k + 1 <= STAGES - 1) ? SEL_W'(k + 1) : '0;
      end
      if (rt_hit[k]) begin
        rt_stall = ld_q[k] && (k < LOAD_RDY - 1);
        rt_sel   = (k + 1 <= STAGES - 1) ? SEL_W'(k + 1) : '0;
      end
    end
  end

  assign stall_o = rs_stall | rt_stall;

  // Nothing real enters EX when stalling, flushing or when ID is empty.
  assign bubble = stall_o | ex_flush_i | ~id_valid_i;

  // Entry 0 takes the instruction leaving ID; older entries shift down.
  assign v_d[0]  = ~bubble & id_regwrite_i & (id_rd_i != '0);
  assign ld_d[0] = id_load_i;
  assign rd_d[0] = id_rd_i;

  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_shift
      assign v_d[gi]  = v_q[gi-1];
      assign ld_d[gi] = ld_q[gi-1];
      assign rd_d[gi] = rd_q[gi-1];
    end
  endgenerate

  assign fwd_rs_d = bubble ? '0 : rs_sel;
  assign fwd_rt_d = bubble ? '0 : rt_sel;

  // Saturating stall counter: holds at all-ones instead of wrapping.
  assign cnt_d = (stall_o && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  // State update: entry pipeline, forwarding selects and stall counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_q      <= '0;
      ld_q     <= '0;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k] <= '0;
      end
      fwd_rs_q <= '0;
      fwd_rt_q <= '0;
      cnt_q    <= '0;
    end else begin
      v_q      <= v_d;
      ld_q     <= ld_d;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k] <= rd_d[k];
      end
      fwd_rs_q <= fwd_rs_d;
      fwd_rt_q <= fwd_rt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fwd_rs_o    = fwd_rs_q;
  assign fwd_rt_o    = fwd_rt_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus a 4-bit
// counter instance driven by the same instruction stream.
module tb_hazard_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic        id_use_rs_i;
  logic        id_use_rt_i;
  logic [4:0]  id_rd_i;
  logic        id_regwrite_i;
  logic        id_load_i;
  logic        ex_flush_i;

  logic        stall_o;
  logic [1:0]  fwd_rs_o;
  logic [1:0]  fwd_rt_o;
  logic [15:0] stall_cnt_o;

  logic        stall_c4;
  logic [1:0]  fwd_rs_c4;
  logic [1:0]  fwd_rt_c4;
  logic [3:0]  stall_cnt_c4;

  int checks     = 0;
  int failures   = 0;
  int exp_stalls = 0;

  hazard_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_load_i(id_load_i),
    .ex_flush_i(ex_flush_i), .stall_o(stall_o),
    .fwd_rs_o(fwd_rs_o), .fwd_rt_o(fwd_rt_o), .stall_cnt_o(stall_cnt_o)
  );

  hazard_scoreboard #(.CNT_W(4)) dut_c4 (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_load_i(id_load_i),
    .ex_flush_i(ex_flush_i), .stall_o(stall_c4),
    .fwd_rs_o(fwd_rs_c4), .fwd_rt_o(fwd_rt_c4), .stall_cnt_o(stall_cnt_c4)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one ID-stage instruction, then settle to mid-cycle.
  task automatic issue(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic fl);
    id_valid_i    = v;
    id_rs_i       = rs;
    id_use_rs_i   = urs;
    id_rt_i       = rt;
    id_use_rt_i   = urt;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_load_i     = ld;
    ex_flush_i    = fl;
    $display("txn t=%0t v=%0b rs=%0d/%0b rt=%0d/%0b rd=%0d rw=%0b ld=%0b flush=%0b",
             $time, v, rs, urs, rt, urt, rd, rw, ld, fl);
    #3;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  task automatic check_fwd(input string tag, input logic [1:0] exp_rs, input logic [1:0] exp_rt);
    check({tag, "_fwd_rs"}, 32'(fwd_rs_o), 32'(exp_rs));
    check({tag, "_fwd_rt"}, 32'(fwd_rt_o), 32'(exp_rt));
  endtask

  initial begin
    // Reset held while a load and its consumer sit in ID.
    rst_i = 1'b0;
    issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    #2;
    check("rst_stall", 32'(stall_o), 32'd0);
    check_fwd("rst", 2'd0, 2'd0);
    check("rst_cnt", 32'(stall_cnt_o), 32'd0);
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    tick();
    check("post_rst_stall", 32'(stall_o), 32'd0);
    check_fwd("post_rst", 2'd0, 2'd0);
    check("post_rst_cnt", 32'(stall_cnt_o), 32'd0);

    // Back-to-back ALU dependency: add $3 then sub reading $3.
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    check("alu_w_stall", 32'(stall_o), 32'd0);
    tick();
    issue(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    check("alu_r_stall", 32'(stall_o), 32'd0);
    tick();
    check_fwd("alu", 2'd1, 2'd0);

    // Load-use: lw $5 then a reader of rt=5, one stall then fwd from WB.
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    check("lu_w_stall", 32'(stall_o), 32'd0);
    tick();
    issue(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    check("lu_stall", 32'(stall_o), 32'd1);
    exp_stalls++;
    tick();
    check("lu_cnt1", 32'(stall_cnt_o), 32'(exp_stalls));
    check_fwd("lu_bubble", 2'd0, 2'd0);
    issue(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    check("lu_release", 32'(stall_o), 32'd0);
    tick();
    check_fwd("lu", 2'd0, 2'd2);
    check("lu_cnt_hold", 32'(stall_cnt_o), 32'(exp_stalls));

    // Youngest wins: two writers of $4, reader picks the EX-stage one.
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check("young_stall", 32'(stall_o), 32'd0);
    tick();
    check_fwd("young", 2'd1, 2'd0);

    // Distance 1 and 2 between writer and reader.
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_fwd("dist1", 2'd2, 2'd1);
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check("dist2_stall", 32'(stall_o), 32'd0);
    tick();
    check_fwd("dist2", 2'd0, 2'd0);

    // Unused source: lw $5 followed by an instruction not reading rs.
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("nouse_stall", 32'(stall_o), 32'd0);
    tick();
    check_fwd("nouse", 2'd0, 2'd0);

    // Register zero: load to $0 followed by reader of $0.
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    check("r0_stall", 32'(stall_o), 32'd0);
    tick();
    check_fwd("r0", 2'd0, 2'd0);

    // Flushed load never becomes a writer.
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    check("flush_stall", 32'(stall_o), 32'd0);
    tick();
    check_fwd("flush", 2'd0, 2'd0);

    // Stall coinciding with flush: bubble inserted, stall still counted.
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd11, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    check("sf_stall", 32'(stall_o), 32'd1);
    exp_stalls++;
    tick();
    check("sf_cnt", 32'(stall_cnt_o), 32'(exp_stalls));
    check_fwd("sf_bubble", 2'd0, 2'd0);
    issue(1'b1, 5'd11, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    check("sf_release", 32'(stall_o), 32'd0);
    tick();
    check_fwd("sf", 2'd2, 2'd0);

    // Reset asserted mid-stall clears entries and counter at once.
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    check("mid_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    check("mid_rst_cnt", 32'(stall_cnt_o), 32'd0);
    check("mid_rst_cnt4", 32'(stall_cnt_c4), 32'd0);
    tick();
    rst_i = 1'b1;
    exp_stalls = 0;
    issue(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    check("mid_after_stall", 32'(stall_o), 32'd0);
    tick();
    check_fwd("mid_after", 2'd0, 2'd0);
    check("mid_after_cnt", 32'(stall_cnt_o), 32'd0);

    // Counter saturation: 20 load-use stalls, 4-bit counter holds 15.
    drain();
    for (int i = 0; i < 20; i++) begin
      issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      check("sat_stall", 32'(stall_o), 32'd1);
      check("sat_stall_c4", 32'(stall_c4), 32'd1);
      exp_stalls++;
      tick();
      issue(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      tick();
      check("sat_cnt16", 32'(stall_cnt_o), 32'(exp_stalls));
      check("sat_cnt4", 32'(stall_cnt_c4), (exp_stalls > 15) ? 32'd15 : 32'(exp_stalls));
    end
    check("sat_final4", 32'(stall_cnt_c4), 32'd15);
    check("sat_final16", 32'(stall_cnt_o), 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
